// File: rtl/parity_serial_rx_if.sv
// Serial receive port bundle: the line in, the reassembled word and status out.
interface parity_serial_rx_if #(
  parameter int DATA_W = 4
);
  logic              rx;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (output rx, input data, valid, parity_err, frame_err, busy);
  modport slave  (input rx, output data, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/parity_serial_rx.sv
// Asynchronous serial receiver: start, DATA_W bits LSB first, XOR parity, stop.
// Reports the word with parity and framing error flags on a one-cycle valid pulse.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on the synchronized line
// START  | timing to mid start bit; a high sample there is a glitch
// DATA   | sampling data bits every bit period, shifting in LSB first
// PARITY | sampling the parity bit and latching the mismatch
// STOP   | sampling the stop bit, then publishing the frame
module parity_serial_rx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input logic               clk,
  input logic               rst_n,
  parity_serial_rx_if.slave bus
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic             ODD       = (ODD_PARITY != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic              rx_meta, rx_s, rx_d;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [DATA_W:0]   shift_in;
  logic              perr, perr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              valid_q, valid_nxt;
  logic              perr_q, perr_q_nxt;
  logic              ferr_q, ferr_q_nxt;
  logic              fall, tick;

  assign fall     = rx_d & ~rx_s;
  assign tick     = (timer == '0);
  assign shift_in = {rx_s, shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      state   <= IDLE;
      timer   <= '0;
      idx     <= '0;
      shift   <= '0;
      perr    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      state   <= state_nxt;
      timer   <= timer_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      perr    <= perr_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      perr_q  <= perr_q_nxt;
      ferr_q  <= ferr_q_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    idx_nxt    = idx;
    shift_nxt  = shift;
    perr_nxt   = perr;
    data_nxt   = data_q;
    valid_nxt  = 1'b0;
    perr_q_nxt = perr_q;
    ferr_q_nxt = ferr_q;

    // Down-counter reloads on terminal count so samples land one bit period apart.
    if (state != IDLE) timer_nxt = tick ? BIT_LOAD : timer - TMR_W'(1);

    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          timer_nxt = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = shift_in[DATA_W:1];
          if (idx == LAST_IDX) state_nxt = PARITY;
          else                 idx_nxt   = idx + IDX_W'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          perr_nxt  = rx_s ^ (^shift) ^ ODD;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          data_nxt   = shift;
          perr_q_nxt = perr;
          ferr_q_nxt = ~rx_s;
          valid_nxt  = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_parity_serial_rx.sv
// Randomized bench for parity_serial_rx: even and odd parity receivers share one line
// and every published frame is compared with a frame-level reference model.
module tb_parity_serial_rx;
  localparam int DATA_W  = 4;
  localparam int CPB     = 4;
  localparam int LATENCY = 2 + CPB / 2 + (DATA_W + 2) * CPB + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              perr_e;
    logic              perr_o;
    logic              ferr;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  parity_serial_rx_if #(.DATA_W(DATA_W)) bus_e ();
  parity_serial_rx_if #(.DATA_W(DATA_W)) bus_o ();
  assign bus_e.rx = rx_line;
  assign bus_o.rx = rx_line;

  parity_serial_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bus(bus_e));
  parity_serial_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bus(bus_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame-level model: parity error when the received parity disagrees with the
  // number of ones in the word under the chosen convention.
  task automatic expect_frame(input logic [DATA_W-1:0] d, input logic p, input logic s);
    exp_t e;
    logic ones_odd;
    ones_odd = ($countones(d) % 2) == 1;
    e.data   = d;
    e.perr_e = (p != ones_odd);
    e.perr_o = (p != !ones_odd);
    e.ferr   = !s;
    e.cyc    = cyc + LATENCY;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    rx_line = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s);
    expect_frame(d, p, s);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_e.valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("valid_cycle", cyc, e.cyc);
          check("data", bus_e.data, e.data);
          check("parity_err_even", bus_e.parity_err, e.perr_e);
          check("frame_err", bus_e.frame_err, e.ferr);
          check("busy_at_valid", bus_e.busy, 0);
          check("odd_valid", bus_o.valid, 1);
          check("parity_err_odd", bus_o.parity_err, e.perr_o);
          check("odd_data", bus_o.data, e.data);
        end
      end else if (bus_o.valid) begin
        check("odd_only_valid", 1, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic busy_seen;
    logic [DATA_W-1:0] d;
    logic p, s;

    repeat (3) @(posedge clk);
    #1;
    check("reset_data", bus_e.data, 0);
    check("reset_valid", bus_e.valid, 0);
    check("reset_busy", bus_e.busy, 0);
    check("reset_flags", {bus_e.parity_err, bus_e.frame_err}, 0);
    rst_n = 1'b1;
    idle(2 * CPB);
    check("idle_busy", bus_e.busy, 0);

    // Good frame, then parity error on the even receiver only.
    send_frame(4'hB, 1'b1, 1'b1);
    idle(2 * CPB);
    send_frame(4'h6, 1'b1, 1'b1);
    idle(2 * CPB);

    // Framing error with the line held low, which must not retrigger.
    send_frame(4'h5, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle(2 * CPB);
    send_frame(4'hA, 1'b0, 1'b1);
    idle(3 * CPB);

    // One-cycle glitch: busy pulses, outputs hold.
    rx_line = 1'b0;
    @(posedge clk);
    #1;
    rx_line = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus_e.busy) busy_seen = 1'b1;
    end
    check("false_start_busy_seen", busy_seen, 1);
    check("false_start_busy_end", bus_e.busy, 0);
    check("false_start_data_held", bus_e.data, 4'hA);
    check("false_start_flags_held", {bus_e.parity_err, bus_e.frame_err}, 0);

    // Reset in the middle of frame 4'hF.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("midframe_busy", bus_e.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_data", bus_e.data, 0);
    check("midframe_rst_busy", bus_e.busy, 0);
    check("midframe_rst_valid", bus_e.valid, 0);
    check("midframe_rst_flags", {bus_e.parity_err, bus_e.frame_err}, 0);
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2 * CPB);
    send_frame(4'h3, 1'b0, 1'b1);
    idle(2 * CPB);

    // Back-to-back frames, no idle beyond the stop bit.
    send_frame(4'h1, 1'b1, 1'b1);
    send_frame(4'hE, 1'b1, 1'b1);
    send_frame(4'h7, 1'b1, 1'b1);
    idle(2 * CPB);

    // Random frames with random parity, occasional bad stop bits and random gaps.
    for (int n = 0; n < 16; n++) begin
      d = DATA_W'($urandom_range(0, 15));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s);
      if (!s) drive_bit(1'b1);
      idle($urandom_range(0, 6));
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("all_frames_received", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
